// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage types and constants
package fetch_unit_pkg;
    localparam int INSTR_W = 32;
    localparam int DEF_ADDR_W = 6;
    localparam logic [INSTR_W-1:0] NOP = 32'h0;
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
endpackage

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: program counter with +1 increment and redirect override
module pc_reg #(
    parameter int ADDR_W = 6,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] pc
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_target;
        else if (advance) pc <= pc + 1'b1;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with BOOT/RUN/HALT control and IF/ID register; FETCH_COUNT_EN adds a capture counter
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rd,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               halt_req,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               halted,
    output logic [31:0]        fetch_count
);
    state_t state;
    logic [ADDR_W-1:0] pc;
    logic run, redir, advance;

    assign run       = state == RUN;
    assign redir     = run && redirect_valid;
    assign advance   = run && !redirect_valid && !halt_req && !stall;
    assign imem_addr = pc;

    pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk(clk),
        .rst_n(rst_n),
        .advance(advance),
        .redirect_valid(redir),
        .redirect_target(redirect_target),
        .pc(pc)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= BOOT;
            if_valid <= 1'b0;
            if_instr <= NOP;
            if_pc    <= '0;
            halted   <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (redirect_valid) if_valid <= 1'b0;
                    else if (halt_req) begin
                        state    <= HALT;
                        if_valid <= 1'b0;
                        halted   <= 1'b1;
                    end else if (!stall) begin
                        if_instr <= imem_rd;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                    end
                end
                default: state <= HALT;
            endcase
        end

`ifdef FETCH_COUNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) fetch_count <= '0;
        else if (advance) fetch_count <= fetch_count + 1'b1;
`else
    assign fetch_count = 32'h0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a behavioural model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rd;
    logic        stall = 1'b0, redirect_valid = 1'b0, halt_req = 1'b0;
    logic [5:0]  redirect_target = '0;
    logic        if_valid, halted;
    logic [31:0] if_instr, fetch_count;
    logic [5:0]  if_pc;

    logic [31:0] mem [64];
    int errors = 0, checks = 0;

    bit          m_boot, m_halt, m_v;
    int          m_pc, m_ipc;
    logic [31:0] m_instr, m_cnt;

    always #5 clk = ~clk;
    assign imem_rd = mem[imem_addr];

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt_req(halt_req), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .halted(halted), .fetch_count(fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_count();
`ifdef FETCH_COUNT_EN
        return m_cnt;
`else
        return 32'h0;
`endif
    endfunction

    task automatic check_all();
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_v});
        chk("if_instr", if_instr, m_instr);
        chk("if_pc", {26'b0, if_pc}, m_ipc);
        chk("imem_addr", {26'b0, imem_addr}, m_pc);
        chk("halted", {31'b0, halted}, {31'b0, m_halt});
        chk("fetch_count", fetch_count, exp_count());
    endtask

    function automatic void model_reset();
        m_boot = 1; m_halt = 0; m_v = 0; m_pc = 0; m_ipc = 0; m_instr = 0; m_cnt = 0;
    endfunction

    // one rising edge of the fetch stage as described behaviourally
    function automatic void model_step(bit s, bit r, int t, bit h);
        if (m_boot) m_boot = 0;
        else if (!m_halt) begin
            if (r) begin m_pc = t; m_v = 0; end
            else if (h) begin m_halt = 1; m_v = 0; end
            else if (!s) begin
                m_instr = mem[m_pc]; m_ipc = m_pc; m_v = 1;
                m_pc = (m_pc + 1) % 64; m_cnt = m_cnt + 1;
            end
        end
    endfunction

    task automatic cycle(input bit s, input bit r, input int t, input bit h);
        stall = s; redirect_valid = r; redirect_target = 6'(t); halt_req = h;
        @(posedge clk);
        model_step(s, r, t, h);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_cycle();
        cycle($urandom % 4 == 0, $urandom % 8 == 0, $urandom % 64, $urandom % 40 == 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h28020005; mem[1] = 32'h2803000c;
        mem[2] = 32'h2867fff7; mem[3] = 32'h04e22000;
        mem[10] = 32'h0;
        @(negedge clk);
        do_reset();
        cycle(0, 0, 0, 0);
        chk("boot_valid", {31'b0, if_valid}, 32'd0);
        repeat (3) cycle(0, 0, 0, 0);
        chk("pc2_instr", if_instr, 32'h2867fff7);
        repeat (3) cycle(1, 0, 0, 0);
        chk("stall_addr", {26'b0, imem_addr}, 32'd3);
        repeat (2) cycle(0, 0, 0, 0);
        for (int i = 0; i < 64 && m_pc != 7; i++) cycle(0, 0, 0, 0);
        cycle(1, 1, 17, 0);
        chk("redir_addr", {26'b0, imem_addr}, 32'd17);
        cycle(0, 0, 0, 0);
        chk("redir_pc", {26'b0, if_pc}, 32'd17);
        cycle(0, 1, 63, 0);
        cycle(0, 0, 0, 0);
        chk("pc63", {26'b0, if_pc}, 32'd63);
        cycle(0, 0, 0, 0);
        chk("wrap_pc", {26'b0, if_pc}, 32'd0);
        chk("wrap_valid", {31'b0, if_valid}, 32'd1);
        cycle(0, 1, 5, 0);
        cycle(0, 0, 0, 1);
        repeat (12) cycle($urandom % 2, $urandom % 2, $urandom % 64, $urandom % 2);
        chk("halt_addr", {26'b0, imem_addr}, 32'd5);
        chk("halt_flag", {31'b0, halted}, 32'd1);
        @(posedge clk); #2;
        do_reset();
        chk("rst_addr", {26'b0, imem_addr}, 32'd0);
        cycle(1, 1, 9, 1);
        repeat (5) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 40, 0);
        repeat (5) cycle(0, 0, 0, 0);
`ifdef FETCH_COUNT_EN
        chk("fcount10", fetch_count, 32'd10);
`else
        chk("fcount0", fetch_count, 32'd0);
`endif
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 60 == 0) do_reset();
            rand_cycle();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage.
- Owns the program counter and drives the word address of the asynchronous-read instruction memory, which has a 6-bit word address and 32-bit data.
- Captures the returned word into the IF/ID register for decode.
- Handles pipeline stalls, control-flow redirects from execute, and a halt request.

Parameters:
- ADDR_W, 6, width of the word address into instruction memory.
- RESET_PC, 0, PC value loaded on reset (word address).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  ADDR_W  word address to instruction memory; equals pc combinationally.
- imem_rd  input  32  instruction word returned combinationally for imem_addr.
- stall  input  1  decode cannot accept; hold pc and the IF/ID register.
- redirect_valid  input  1  branch or jump taken in execute.
- redirect_target  input  ADDR_W  new word address for pc.
- halt_req  input  1  stop fetching.
- if_valid  output  1  if_instr/if_pc hold a live instruction.
- if_instr  output  32  registered instruction word.
- if_pc  output  ADDR_W  word address if_instr was fetched from.
- halted  output  1  unit is in HALT.
- fetch_count  output  32  number of instructions accepted into IF/ID (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, state=BOOT.
  - if_valid=0, if_instr=0, if_pc=0, halted=0, fetch_count=0.
  - Applies immediately, mid-operation included.
- State machine BOOT, RUN, HALT:
  - BOOT: lasts exactly one cycle after rst_n rises. No capture, pc held, if_valid=0. Next state RUN unconditionally; redirect_valid, halt_req and stall are ignored.
  - RUN: per-edge priority is redirect > halt > stall > advance.
    - redirect_valid=1: pc<=redirect_target, if_valid<=0 (squash the wrong-path word), if_instr/if_pc hold. Applies even when stall=1.
    - halt_req=1 (no redirect): state<=HALT, if_valid<=0, pc holds.
    - stall=1: pc, if_valid, if_instr, if_pc all hold.
    - otherwise: if_instr<=imem_rd, if_pc<=pc, if_valid<=1, pc<=pc+1.
  - HALT: halted=1, if_valid=0, pc frozen, all inputs ignored. Exit only by reset.
- Fetch latency: one cycle from pc presentation to if_valid=1.
  - Throughput: one instruction per cycle without stall or redirect.
  - First valid instruction appears on the 2nd rising edge after rst_n deasserts.
- pc arithmetic:
  - Unsigned, ADDR_W bits, wraps at the top (63+1 -> 0).
  - The wrap is silent; there is no error flag.
- The first cycle after a redirect presents redirect_target on imem_addr. The following edge captures that word normally unless stalled.
- Instruction word 0 (nop) is captured and counted like any other word; there is no special-casing.
- Outputs if_* are registered only. imem_addr is the only combinational output.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined: fetch_count increments by 1 on every RUN advance edge (if_valid<=1 capture). It wraps modulo 2^32, clears on reset, and freezes in HALT.
- Not defined: fetch_count is tied to 32'h0 and no counter flops exist. The port list is identical in both builds.

Decomposition:
- Shared package holds:
  - the fetch state encoding (BOOT, RUN, HALT);
  - INSTR_W=32;
  - the NOP word constant 32'h0;
  - the default ADDR_W.
- One natural sub-module: pc_reg.
  - Contents: PC flop, +1 incrementer and redirect mux.
  - Inputs: advance, redirect_valid, redirect_target.
  - fetch_unit keeps the FSM and the IF/ID register.

Test Plan:
- Reset release, memory words 0..3 = 28020005, 2803000c, 2867fff7, 04e22000, no stall
  -> if_valid=0 during BOOT;
  -> then if_pc 0,1,2,3 with matching if_instr on consecutive cycles.
- Stall held high for 3 cycles while if_pc=2
  -> if_pc=2, if_instr=2867fff7 and imem_addr=3 unchanged for all 3 cycles;
  -> fetch resumes at 3 on release.
- redirect_valid=1 with target=17 while stall=1 at pc=7
  -> next cycle if_valid=0 and imem_addr=17;
  -> following edge if_pc=17.
- Start at pc=63 via redirect
  -> if_pc=63, then if_pc=0 (wrap);
  -> no spurious if_valid gap.
- halt_req pulsed for 1 cycle at pc=5
  -> halted=1, if_valid=0, imem_addr stays 5 for ≥10 cycles despite redirect/stall activity;
  -> rst_n pulse returns to BOOT with pc=0.
- With FETCH_COUNT_EN: 10 advances, 2 stalls, 1 redirect
  -> fetch_count=10.
- Without FETCH_COUNT_EN, same stimulus
  -> fetch_count=0.
